// File: rtl/wspr_symbol_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : wspr_symbol_sequencer_pkg
// Brief    : Shared state encoding, WSPR frame constants and tone helper.
// Revision : 1.0
// ---------------------------------------------------------------------------
package wspr_symbol_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PRE   = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    localparam int c_sym_count = 162;
    localparam int c_sym_width = 2;
    localparam int c_ram_depth = 256;

    // Defaults for a 76.8 MHz system clock
    localparam int c_sym_clks  = 52_428_800;
    localparam int c_pre_clks  = 7_680_000;
    localparam int c_tone_step = 82;

    function automatic logic [31:0] tone_offset(input logic [1:0] sym, input logic [31:0] step);
        return 32'(sym) * step;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wspr_symbol_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : wspr_symbol_ram
// Brief    : Single-write / single-read symbol store with registered read.
// Revision : 1.0
// ---------------------------------------------------------------------------
module wspr_symbol_ram
    import wspr_symbol_sequencer_pkg::*;
#(
    parameter int DEPTH = c_ram_depth,
    parameter int WIDTH = c_sym_width,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Contents survive reset so a frame can be replayed after recovery
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/wspr_symbol_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : wspr_symbol_sequencer
// Brief    : Steps a stored 4-FSK WSPR frame out as tuning words plus PTT.
// Revision : 1.0
// ---------------------------------------------------------------------------
module wspr_symbol_sequencer
    import wspr_symbol_sequencer_pkg::*;
#(
    parameter int SYM_CLKS  = c_sym_clks,
    parameter int PRE_CLKS  = c_pre_clks,
    parameter int SYM_COUNT = c_sym_count,
    parameter int TONE_STEP = c_tone_step
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sym_wr_en,
    input  logic [7:0]  sym_wr_addr,
    input  logic [1:0]  sym_wr_data,
    input  logic [31:0] base_freq,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] frequency,
    output logic        PTT,
    output logic        busy,
    output logic [7:0]  sym_index,
    output logic        done
);

    localparam logic [8:0]  c_count_w  = 9'(SYM_COUNT);
    localparam logic [7:0]  c_last_idx = 8'(SYM_COUNT - 1);
    localparam logic [31:0] c_sym_load = 32'(SYM_CLKS - 1);
    localparam logic [31:0] c_pre_load = 32'(PRE_CLKS - 1);
    localparam logic [31:0] c_step     = 32'(TONE_STEP);

    state_t      r_state;
    logic [31:0] r_base_q;
    logic [31:0] r_cnt;
    logic [31:0] r_frequency;
    logic        r_ptt;
    logic        r_busy;
    logic [7:0]  r_sym_index;
    logic        r_done;

    logic        w_wr_accept;
    logic        w_rd_en;
    logic [7:0]  w_rd_addr;
    logic [1:0]  w_rd_data;
    logic [31:0] w_tone_freq;

    assign w_wr_accept = sym_wr_en && (r_state == ST_IDLE) && ({1'b0, sym_wr_addr} < c_count_w);
    assign w_tone_freq = r_base_q + tone_offset(w_rd_data, c_step);

    // Read at start for symbol 0, and one cycle before each boundary for the next symbol
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = 8'd0;
        if ((r_state == ST_IDLE) && start && !abort) begin
            w_rd_en = 1'b1;
        end else if ((r_state == ST_SEND) && (r_cnt == 32'd1)) begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_sym_index + 8'd1;
        end
    end

    wspr_symbol_ram u_ram (
        .clk     (clk),
        .wr_en   (w_wr_accept),
        .wr_addr (sym_wr_addr),
        .wr_data (sym_wr_data),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_base_q    <= 32'd0;
            r_cnt       <= 32'd0;
            r_frequency <= 32'd0;
            r_ptt       <= 1'b0;
            r_busy      <= 1'b0;
            r_sym_index <= 8'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state != ST_IDLE) && abort) begin
                r_state     <= ST_IDLE;
                r_frequency <= 32'd0;
                r_ptt       <= 1'b0;
                r_busy      <= 1'b0;
                r_sym_index <= 8'd0;
                r_cnt       <= 32'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_base_q <= base_freq;
                            r_busy   <= 1'b1;
                            r_state  <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        r_frequency <= w_tone_freq;
                        r_ptt       <= 1'b1;
                        r_cnt       <= c_pre_load;
                        r_state     <= ST_PRE;
                    end
                    ST_PRE: begin
                        if (r_cnt == 32'd0) begin
                            r_cnt       <= c_sym_load;
                            r_sym_index <= 8'd0;
                            r_state     <= ST_SEND;
                        end else begin
                            r_cnt <= r_cnt - 32'd1;
                        end
                    end
                    ST_SEND: begin
                        if (r_cnt != 32'd0) begin
                            r_cnt <= r_cnt - 32'd1;
                        end else if (r_sym_index < c_last_idx) begin
                            r_frequency <= w_tone_freq;
                            r_sym_index <= r_sym_index + 8'd1;
                            r_cnt       <= c_sym_load;
                        end else begin
                            r_frequency <= 32'd0;
                            r_ptt       <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_sym_index <= 8'd0;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign frequency = r_frequency;
    assign PTT       = r_ptt;
    assign busy      = r_busy;
    assign sym_index = r_sym_index;
    assign done      = r_done;

endmodule
`default_nettype wire
